// File: rtl/eeg_pea_pkg.sv
// Shared constants and state encoding for the PE output packer.
package eeg_pea_pkg;
  localparam int OPK_DATA_OUT_DW = 8;
  localparam int OPK_ORAM_DW     = 32;
  localparam int PACK_NUM        = OPK_ORAM_DW / OPK_DATA_OUT_DW;
  localparam int LANE_AW         = $clog2(PACK_NUM);

  typedef enum logic [3:0] {
    OPK_IDLE = 4'b0001,
    OPK_FILL = 4'b0010,
    OPK_FLSH = 4'b0100,
    OPK_WAIT = 4'b1000
  } opk_state_e;
endpackage

// File: rtl/eeg_cpm_reg_slice.sv
// One-deep valid/ready register: accepts whenever empty or draining this cycle.
module eeg_cpm_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  assign in_rdy = ~out_vld | out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld <= 1'b1;
      out_dat <= in_dat;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/eeg_pea_eng_opk.sv
// PE output packer: merges per-sample results into byte-strobed ORAM word writes,
// with optional ReLU and a DONE pulse once the layer's last word is accepted.
module eeg_pea_eng_opk
  import eeg_pea_pkg::*;
#(
  parameter int DATA_OUT_DW = OPK_DATA_OUT_DW,
  parameter int OMUX_ADD_AW = 8,
  parameter int ORAM_DW     = OPK_ORAM_DW,
  parameter int ORAM_ADD_AW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ORAM_ADD_AW-1:0] CFG_OPK_BASE,
  input  logic                   CFG_OPK_RELU,
  output logic                   IS_IDLE,
  input  logic                   DIN_VLD,
  input  logic                   DIN_LST,
  input  logic [OMUX_ADD_AW-1:0] DIN_ADD,
  input  logic [DATA_OUT_DW-1:0] DIN_DAT,
  output logic                   DIN_RDY,
  output logic                   ORAM_WR_VLD,
  output logic [ORAM_ADD_AW-1:0] ORAM_WR_ADD,
  output logic [ORAM_DW-1:0]     ORAM_WR_DAT,
  output logic [PACK_NUM-1:0]    ORAM_WR_STB,
  input  logic                   ORAM_WR_RDY,
  output logic                   DONE
);

  localparam int WIDX_W  = OMUX_ADD_AW - LANE_AW;
  localparam int SLICE_W = ORAM_ADD_AW + ORAM_DW + PACK_NUM;

  opk_state_e state, state_nxt;

  logic [LANE_AW-1:0]            lane;
  logic [WIDX_W-1:0]             widx;
  logic signed [DATA_OUT_DW-1:0] sample;
  logic                          same_word;
  logic                          accept;
  logic                          out_free;
  logic                          push;
  logic                          done_nxt;

  logic [ORAM_DW-1:0]  buf_dat, buf_dat_nxt;
  logic [PACK_NUM-1:0] buf_stb, buf_stb_nxt;
  logic [WIDX_W-1:0]   buf_widx, buf_widx_nxt;
  logic [SLICE_W-1:0]  push_dat;
  logic [SLICE_W-1:0]  wr_dat;

  function automatic logic signed [DATA_OUT_DW-1:0] apply_relu(
    input logic signed [DATA_OUT_DW-1:0] d,
    input logic                          en
  );
    return (en && d[DATA_OUT_DW-1]) ? '0 : d;
  endfunction

  assign lane      = DIN_ADD[LANE_AW-1:0];
  assign widx      = DIN_ADD[OMUX_ADD_AW-1:LANE_AW];
  assign sample    = apply_relu(signed'(DIN_DAT), CFG_OPK_RELU);
  assign same_word = (widx == buf_widx);
  assign accept    = DIN_VLD & DIN_RDY;
  assign IS_IDLE   = (state == OPK_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OPK_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      OPK_IDLE: if (accept) state_nxt = DIN_LST ? OPK_FLSH : OPK_FILL;
      OPK_FILL: if (accept && DIN_LST) state_nxt = OPK_FLSH;
      OPK_FLSH: if (out_free) state_nxt = OPK_WAIT;
      OPK_WAIT: if (ORAM_WR_VLD && ORAM_WR_RDY) state_nxt = OPK_IDLE;
      default:  state_nxt = OPK_IDLE;
    endcase
  end

  // Output logic: a word change in FILL stalls only while the output register cannot take the old word
  always_comb begin
    DIN_RDY = 1'b0;
    push    = 1'b0;
    unique case (state)
      OPK_IDLE: DIN_RDY = 1'b1;
      OPK_FILL: begin
        DIN_RDY = same_word | out_free;
        push    = DIN_VLD & ~same_word & out_free;
      end
      OPK_FLSH: push = out_free;
      default:  ;
    endcase
  end

  // Pack buffer next value: a new word starts from an empty buffer so unwritten lanes stay zero
  always_comb begin
    buf_dat_nxt  = buf_dat;
    buf_stb_nxt  = buf_stb;
    buf_widx_nxt = buf_widx;
    if (state == OPK_FLSH && out_free) begin
      buf_dat_nxt  = '0;
      buf_stb_nxt  = '0;
      buf_widx_nxt = '0;
    end else if (accept) begin
      if (state == OPK_IDLE || !same_word) begin
        buf_dat_nxt  = '0;
        buf_stb_nxt  = '0;
        buf_widx_nxt = widx;
      end
      buf_dat_nxt[lane*DATA_OUT_DW +: DATA_OUT_DW] = sample;
      buf_stb_nxt[lane]                            = 1'b1;
    end
  end

  assign done_nxt = (state == OPK_WAIT) & ORAM_WR_VLD & ORAM_WR_RDY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_dat  <= '0;
      buf_stb  <= '0;
      buf_widx <= '0;
      DONE     <= 1'b0;
    end else begin
      buf_dat  <= buf_dat_nxt;
      buf_stb  <= buf_stb_nxt;
      buf_widx <= buf_widx_nxt;
      DONE     <= done_nxt;
    end
  end

  // Word address wraps modulo the ORAM address space
  assign push_dat = {CFG_OPK_BASE + ORAM_ADD_AW'(buf_widx), buf_dat, buf_stb};

  eeg_cpm_reg_slice #(
    .W(SLICE_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (push),
    .in_dat  (push_dat),
    .in_rdy  (out_free),
    .out_vld (ORAM_WR_VLD),
    .out_dat (wr_dat),
    .out_rdy (ORAM_WR_RDY)
  );

  assign {ORAM_WR_ADD, ORAM_WR_DAT, ORAM_WR_STB} = wr_dat;

endmodule

// File: tb/tb_eeg_pea_eng_opk.sv
// Directed bench for the PE output packer: ORAM writes are logged and compared to hand-computed words.
module tb_eeg_pea_eng_opk;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  CFG_OPK_BASE;
  logic        CFG_OPK_RELU;
  logic        IS_IDLE;
  logic        DIN_VLD;
  logic        DIN_LST;
  logic [7:0]  DIN_ADD;
  logic [7:0]  DIN_DAT;
  logic        DIN_RDY;
  logic        ORAM_WR_VLD;
  logic [9:0]  ORAM_WR_ADD;
  logic [31:0] ORAM_WR_DAT;
  logic [3:0]  ORAM_WR_STB;
  logic        ORAM_WR_RDY;
  logic        DONE;

  eeg_pea_eng_opk dut (
    .clk          (clk),
    .rst          (rst),
    .CFG_OPK_BASE (CFG_OPK_BASE),
    .CFG_OPK_RELU (CFG_OPK_RELU),
    .IS_IDLE      (IS_IDLE),
    .DIN_VLD      (DIN_VLD),
    .DIN_LST      (DIN_LST),
    .DIN_ADD      (DIN_ADD),
    .DIN_DAT      (DIN_DAT),
    .DIN_RDY      (DIN_RDY),
    .ORAM_WR_VLD  (ORAM_WR_VLD),
    .ORAM_WR_ADD  (ORAM_WR_ADD),
    .ORAM_WR_DAT  (ORAM_WR_DAT),
    .ORAM_WR_STB  (ORAM_WR_STB),
    .ORAM_WR_RDY  (ORAM_WR_RDY),
    .DONE         (DONE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hs_cyc = 0;

  logic [9:0]  q_add[$];
  logic [31:0] q_dat[$];
  logic [3:0]  q_stb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes seen at the falling edge complete at the following rising edge
  always @(negedge clk) begin
    if (!rst && ORAM_WR_VLD && ORAM_WR_RDY) begin
      q_add.push_back(ORAM_WR_ADD);
      q_dat.push_back(ORAM_WR_DAT);
      q_stb.push_back(ORAM_WR_STB);
      hs_cyc = cyc;
    end
    if (DONE) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    q_add.delete();
    q_dat.delete();
    q_stb.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic l);
    logic got;
    int   n;
    DIN_VLD = 1'b1;
    DIN_ADD = a;
    DIN_DAT = d;
    DIN_LST = l;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = DIN_RDY;
      @(posedge clk);
      #1;
      n++;
    end
    DIN_VLD = 1'b0;
    DIN_LST = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: addr %0h not accepted after %0d cycles, required acceptance", a, n);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no DONE within %0d cycles, required a pulse", n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (IS_IDLE !== 1'b1)     begin errors++; $display("FAIL rst_is_idle: got %b required 1", IS_IDLE); end
    checks++; if (DIN_RDY !== 1'b1)     begin errors++; $display("FAIL rst_din_rdy: got %b required 1", DIN_RDY); end
    checks++; if (ORAM_WR_VLD !== 1'b0) begin errors++; $display("FAIL rst_wr_vld: got %b required 0", ORAM_WR_VLD); end
    checks++; if (ORAM_WR_ADD !== 10'h0) begin errors++; $display("FAIL rst_wr_add: got %h required 000", ORAM_WR_ADD); end
    checks++; if (ORAM_WR_DAT !== 32'h0) begin errors++; $display("FAIL rst_wr_dat: got %h required 00000000", ORAM_WR_DAT); end
    checks++; if (ORAM_WR_STB !== 4'h0) begin errors++; $display("FAIL rst_wr_stb: got %b required 0000", ORAM_WR_STB); end
    checks++; if (DONE !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b required 0", DONE); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_contiguous();
    logic [9:0]  ea[2] = '{10'h010, 10'h011};
    logic [31:0] ed[2] = '{32'h04030201, 32'h08070605};
    clear_log();
    CFG_OPK_BASE = 10'h010;
    CFG_OPK_RELU = 1'b0;
    ORAM_WR_RDY  = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(i), 8'(i + 1), i == 7);
    wait_done();
    checks++;
    if (q_add.size() !== 2) begin
      errors++; $display("FAIL contig_count: got %0d writes required 2", q_add.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (q_add[i] !== ea[i] || q_dat[i] !== ed[i] || q_stb[i] !== 4'b1111) begin
          errors++;
          $display("FAIL contig_write%0d: got %h/%h/%b required %h/%h/1111", i, q_add[i], q_dat[i], q_stb[i], ea[i], ed[i]);
        end
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL contig_done_cnt: got %0d required 1", done_cnt); end
    checks++; if (done_cyc !== hs_cyc + 1) begin errors++; $display("FAIL contig_done_lat: got %0d required %0d", done_cyc - hs_cyc, 1); end
    checks++; if (IS_IDLE !== 1'b1) begin errors++; $display("FAIL contig_idle: got %b required 1", IS_IDLE); end
  endtask

  task automatic test_strided();
    logic [9:0]  ea[2] = '{10'h020, 10'h021};
    logic [31:0] ed[2] = '{32'h00220011, 32'h00440033};
    logic [7:0]  dv[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    CFG_OPK_BASE = 10'h020;
    for (int i = 0; i < 4; i++) send(8'(2 * i), dv[i], i == 3);
    wait_done();
    checks++;
    if (q_add.size() !== 2) begin
      errors++; $display("FAIL stride_count: got %0d writes required 2", q_add.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (q_add[i] !== ea[i] || q_dat[i] !== ed[i] || q_stb[i] !== 4'b0101) begin
          errors++;
          $display("FAIL stride_write%0d: got %h/%h/%b required %h/%h/0101", i, q_add[i], q_dat[i], q_stb[i], ea[i], ed[i]);
        end
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stride_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_relu();
    logic [7:0]  dv[4] = '{8'h05, 8'hFB, 8'h80, 8'h7F};
    logic [31:0] ed[2] = '{32'h7F000005, 32'h7F80FB05};
    for (int r = 0; r < 2; r++) begin
      clear_log();
      CFG_OPK_BASE = 10'h030;
      CFG_OPK_RELU = (r == 0);
      for (int i = 0; i < 4; i++) send(8'(i), dv[i], i == 3);
      wait_done();
      checks++;
      if (q_add.size() !== 1) begin
        errors++; $display("FAIL relu%0d_count: got %0d writes required 1", r, q_add.size());
      end else begin
        checks++;
        if (q_add[0] !== 10'h030 || q_dat[0] !== ed[r] || q_stb[0] !== 4'b1111) begin
          errors++;
          $display("FAIL relu%0d_write: got %h/%h/%b required 030/%h/1111", r, q_add[0], q_dat[0], q_stb[0], ed[r]);
        end
      end
    end
    CFG_OPK_RELU = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [9:0]  ea[3] = '{10'h050, 10'h051, 10'h052};
    logic [31:0] ed[3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    clear_log();
    CFG_OPK_BASE = 10'h050;
    ORAM_WR_RDY  = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i), 8'(i + 1), 1'b0);
    DIN_VLD = 1'b1;
    DIN_ADD = 8'd8;
    DIN_DAT = 8'd9;
    DIN_LST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (DIN_RDY !== 1'b0) begin errors++; $display("FAIL bp_din_rdy%0d: got %b required 0", k, DIN_RDY); end
      checks++;
      if (ORAM_WR_VLD !== 1'b1 || ORAM_WR_ADD !== 10'h050 || ORAM_WR_DAT !== 32'h04030201 || ORAM_WR_STB !== 4'b1111) begin
        errors++;
        $display("FAIL bp_hold%0d: got %b/%h/%h/%b required 1/050/04030201/1111", k, ORAM_WR_VLD, ORAM_WR_ADD, ORAM_WR_DAT, ORAM_WR_STB);
      end
      @(posedge clk);
      #1;
    end
    ORAM_WR_RDY = 1'b1;
    for (int i = 8; i < 12; i++) send(8'(i), 8'(i + 1), i == 11);
    wait_done();
    checks++;
    if (q_add.size() !== 3) begin
      errors++; $display("FAIL bp_count: got %0d writes required 3", q_add.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_add[i] !== ea[i] || q_dat[i] !== ed[i] || q_stb[i] !== 4'b1111) begin
          errors++;
          $display("FAIL bp_write%0d: got %h/%h/%b required %h/%h/1111", i, q_add[i], q_dat[i], q_stb[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_last_alone();
    clear_log();
    CFG_OPK_BASE = 10'h3FF;
    send(8'd4, 8'h5A, 1'b1);
    wait_done();
    checks++;
    if (q_add.size() !== 1) begin
      errors++; $display("FAIL wrap_count: got %0d writes required 1", q_add.size());
    end else begin
      checks++;
      if (q_add[0] !== 10'h000 || q_dat[0] !== 32'h0000005A || q_stb[0] !== 4'b0001) begin
        errors++;
        $display("FAIL wrap_write: got %h/%h/%b required 000/0000005a/0001", q_add[0], q_dat[0], q_stb[0]);
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid_layer();
    clear_log();
    CFG_OPK_BASE = 10'h040;
    send(8'd0, 8'hA1, 1'b0);
    send(8'd1, 8'hA2, 1'b0);
    send(8'd2, 8'hA3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (IS_IDLE !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %b required 1", IS_IDLE); end
    checks++; if (DIN_RDY !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy: got %b required 1", DIN_RDY); end
    checks++;
    if (ORAM_WR_VLD !== 1'b0 || ORAM_WR_ADD !== 10'h0 || ORAM_WR_DAT !== 32'h0 || ORAM_WR_STB !== 4'h0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out: got %b/%h/%h/%b/%b required 0/000/00000000/0000/0", ORAM_WR_VLD, ORAM_WR_ADD, ORAM_WR_DAT, ORAM_WR_STB, DONE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (q_add.size() !== 0) begin errors++; $display("FAIL mid_rst_nowrite: got %0d writes required 0", q_add.size()); end
    send(8'd0, 8'h01, 1'b0);
    send(8'd1, 8'h02, 1'b1);
    wait_done();
    checks++;
    if (q_add.size() !== 1) begin
      errors++; $display("FAIL mid_next_count: got %0d writes required 1", q_add.size());
    end else begin
      checks++;
      if (q_add[0] !== 10'h040 || q_dat[0] !== 32'h00000201 || q_stb[0] !== 4'b0011) begin
        errors++;
        $display("FAIL mid_next_write: got %h/%h/%b required 040/00000201/0011", q_add[0], q_dat[0], q_stb[0]);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    CFG_OPK_BASE = 10'h0;
    CFG_OPK_RELU = 1'b0;
    DIN_VLD      = 1'b0;
    DIN_LST      = 1'b0;
    DIN_ADD      = 8'h0;
    DIN_DAT      = 8'h0;
    ORAM_WR_RDY  = 1'b1;
    test_reset();
    test_contiguous();
    test_strided();
    test_relu();
    test_backpressure();
    test_wrap_last_alone();
    test_reset_mid_layer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
